// File: rtl/modexp_arbiter.sv
// rtl/modexp_arbiter.sv - two-requester round-robin front end for one shared modular-exponentiation engine
// Optional WAIT watchdog: define MODEXP_ARB_TIMEOUT_EN.
module modexp_arbiter #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] base0,
    input  logic [WIDTH-1:0] exp0,
    input  logic [WIDTH-1:0] modulus0,
    input  logic [WIDTH-1:0] base1,
    input  logic [WIDTH-1:0] exp1,
    input  logic [WIDTH-1:0] modulus1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result0,
    output logic [WIDTH-1:0] result1,
    output logic             err,
    output logic             busy,
    output logic             md_start,
    output logic [WIDTH-1:0] base,
    output logic [WIDTH-1:0] exp,
    output logic [WIDTH-1:0] modulus,
    input  logic [WIDTH-1:0] r,
    input  logic             md_end
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             owner_q, owner_d;
    logic             grant;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] modulus_q, modulus_d;
    logic [WIDTH-1:0] result0_q, result0_d;
    logic [WIDTH-1:0] result1_q, result1_d;

`ifdef MODEXP_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timed_out_q, timed_out_d;
`else
    // TIMEOUT_CYCLES only sizes the watchdog, which is absent in this build.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    // The pointer only breaks ties; a lone request always wins.
    assign grant = (req0 && req1) ? ptr_q : req1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            ptr_q     <= 1'b0;
            owner_q   <= 1'b0;
            base_q    <= '0;
            exp_q     <= '0;
            modulus_q <= '0;
            result0_q <= '0;
            result1_q <= '0;
`ifdef MODEXP_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            base_q    <= base_d;
            exp_q     <= exp_d;
            modulus_q <= modulus_d;
            result0_q <= result0_d;
            result1_q <= result1_d;
`ifdef MODEXP_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timed_out_q <= timed_out_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        base_d    = base_q;
        exp_d     = exp_q;
        modulus_d = modulus_q;
        result0_d = result0_q;
        result1_d = result1_q;
`ifdef MODEXP_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        timed_out_d = timed_out_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    owner_d   = grant;
                    base_d    = grant ? base1    : base0;
                    exp_d     = grant ? exp1     : exp0;
                    modulus_d = grant ? modulus1 : modulus0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef MODEXP_ARB_TIMEOUT_EN
                cnt_d       = '0;
                timed_out_d = 1'b0;
`endif
            end
            S_WAIT: begin
                if (md_end) begin
                    if (owner_q) result1_d = r;
                    else         result0_d = r;
                    state_d = S_DONE;
                end
`ifdef MODEXP_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    if (owner_q) result1_d = '0;
                    else         result0_d = '0;
                    timed_out_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                ptr_d   = ~owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        md_start = (state_q == S_START);
        busy     = (state_q != S_IDLE);
        done0    = (state_q == S_DONE) && !owner_q;
        done1    = (state_q == S_DONE) &&  owner_q;
`ifdef MODEXP_ARB_TIMEOUT_EN
        err      = (state_q == S_DONE) && timed_out_q;
`else
        err      = 1'b0;
`endif
    end

    assign base    = base_q;
    assign exp     = exp_q;
    assign modulus = modulus_q;
    assign result0 = result0_q;
    assign result1 = result1_q;

endmodule

// File: tb/tb_modexp_arbiter.sv
// tb/tb_modexp_arbiter.sv - vector table plus corner sequences for modexp_arbiter against a behavioural engine
module tb_modexp_arbiter;

    localparam int W = 32;

    logic         clk, rstn, req0, req1, md_end, md_start;
    logic [W-1:0] base0, exp0, modulus0, base1, exp1, modulus1;
    logic [W-1:0] base, exp, modulus, r, result0, result1;
    logic         done0, done1, err, busy;

    modexp_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rstn(rstn), .req0(req0), .req1(req1),
        .base0(base0), .exp0(exp0), .modulus0(modulus0),
        .base1(base1), .exp1(exp1), .modulus1(modulus1),
        .done0(done0), .done1(done1), .result0(result0), .result1(result1),
        .err(err), .busy(busy), .md_start(md_start),
        .base(base), .exp(exp), .modulus(modulus), .r(r), .md_end(md_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           who;
        logic [W-1:0] b, e, m, res;
    } vec_t;

    typedef struct {
        bit           owner;
        logic [W-1:0] res;
        bit           err;
    } exp_t;

    exp_t         sb[$];
    int           vectors = 0;
    int           miscompares = 0;
    bit           ptr_m = 1'b0;
    int           start_cnt = 0;
    bit           engine_hang = 1'b0;
    logic [W-1:0] seen_b, seen_e, seen_m;

    function automatic logic [W-1:0] mexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                          input logic [W-1:0] m);
        logic [63:0] acc, bb, mm;
        mm = {32'd0, m};
        if (m == 0) return '0;
        acc = 64'd1 % mm;
        bb  = {32'd0, b} % mm;
        for (int i = 0; i < W; i++) begin
            if (e[i]) acc = (acc * bb) % mm;
            bb = (bb * bb) % mm;
        end
        return acc[W-1:0];
    endfunction

    // Engine: md_end is raised 5 cycles after md_start is seen.
    initial begin
        int           pend;
        logic [W-1:0] pend_r;
        pend   = 0;
        pend_r = '0;
        md_end = 1'b0;
        r      = '0;
        forever begin
            @(negedge clk);
            md_end = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    md_end = 1'b1;
                    r      = pend_r;
                end
            end
            if (md_start) begin
                start_cnt++;
                seen_b = base;
                seen_e = exp;
                seen_m = modulus;
                if (!engine_hang) begin
                    pend   = 5;
                    pend_r = mexp(base, exp, modulus);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_md_start"}, md_start, 0);
        chk({tag, "_done"}, {done0, done1}, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_operands"}, base | exp | modulus, 0);
        chk({tag, "_results"}, result0 | result1, 0);
    endtask

    task automatic wait_start(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (md_start) seen = 1'b1;
        end
        if (!seen) chk({name, "_start_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input string name);
        bit   seen = 1'b0;
        exp_t e;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done0 || done1) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    chk({name, "_unexpected_done"}, 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk({name, "_owner"}, done1, e.owner);
                    chk({name, "_single_done"}, done0 & done1, 0);
                    chk({name, "_result"}, e.owner ? result1 : result0, e.res);
                    chk({name, "_err"}, err, e.err);
                    ptr_m = ~e.owner;
                end
                if (done0) req0 = 1'b0;
                if (done1) req1 = 1'b0;
                @(negedge clk);
                chk({name, "_done_one_cycle"}, {done0, done1}, 0);
            end
        end
        if (!seen) chk({name, "_done_timeout"}, 0, 1);
    endtask

    task automatic run_pair(input string name);
        exp_t e;
        base0 = 4; exp0 = 13; modulus0 = 497;
        base1 = 2; exp1 = 10; modulus1 = 1000;
        e.owner = ptr_m;  e.res = ptr_m ? 24 : 445; e.err = 0; sb.push_back(e);
        e.owner = ~ptr_m; e.res = ptr_m ? 445 : 24; e.err = 0; sb.push_back(e);
        req0 = 1'b1;
        req1 = 1'b1;
        wait_done({name, "_first"});
        wait_done({name, "_second"});
    endtask

    initial begin
        vec_t         tbl[8];
        exp_t         e;
        int           sc0, n;
        logic [W-1:0] other;

        tbl[0] = '{0, 4, 13, 497, 445};
        tbl[1] = '{1, 2, 10, 1000, 24};
        tbl[2] = '{1, 3, 5, 7, 5};
        tbl[3] = '{0, 10, 2, 7, 2};
        tbl[4] = '{0, 7, 0, 13, 1};
        tbl[5] = '{1, 2, 31, 1000, 648};
        tbl[6] = '{0, 5, 3, 1, 0};
        tbl[7] = '{1, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 1};

        rstn = 1'b0; req0 = 1'b0; req1 = 1'b0;
        base0 = '0; exp0 = '0; modulus0 = '0;
        base1 = '0; exp1 = '0; modulus1 = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            sc0   = start_cnt;
            other = tbl[i].who ? result0 : result1;
            if (tbl[i].who) begin
                base1 = tbl[i].b; exp1 = tbl[i].e; modulus1 = tbl[i].m; req1 = 1'b1;
                base0 = $urandom; exp0 = $urandom; modulus0 = $urandom;
            end else begin
                base0 = tbl[i].b; exp0 = tbl[i].e; modulus0 = tbl[i].m; req0 = 1'b1;
                base1 = $urandom; exp1 = $urandom; modulus1 = $urandom;
            end
            e.owner = tbl[i].who; e.res = tbl[i].res; e.err = 0;
            sb.push_back(e);
            wait_done($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_starts", i), start_cnt - sc0, 1);
            chk($sformatf("vec%0d_other_held", i), tbl[i].who ? result0 : result1, other);
        end

        base0 = 4; exp0 = 13; modulus0 = 497; req0 = 1'b1;
        e.owner = 0; e.res = 445; e.err = 0;
        sb.push_back(e);
        wait_start("capture");
        base0 = '0; exp0 = '0; modulus0 = '0; req0 = 1'b0;
        @(negedge clk);
        chk("capture_base_reg", {base, exp, modulus}, {32'd4, 32'd13, 32'd497});
        wait_done("capture");
        chk("capture_engine_ops", {seen_b, seen_e, seen_m}, {32'd4, 32'd13, 32'd497});

        base0 = 4; exp0 = 13; modulus0 = 497; req0 = 1'b1;
        wait_start("midreset");
        @(negedge clk);
        #2 rstn = 1'b0;
        req0 = 1'b0;
        #1 chk_all_zero("midreset");
        @(negedge clk);
        rstn  = 1'b1;
        ptr_m = 1'b0;
        sc0   = start_cnt;
        n     = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done0 || done1 || busy) n++;
        end
        chk("midreset_no_done_no_busy", n, 0);
        chk("midreset_no_restart", start_cnt - sc0, 0);

        run_pair("pair_a");
        base0 = 4; exp0 = 13; modulus0 = 497; req0 = 1'b1;
        e.owner = 0; e.res = 445; e.err = 0;
        sb.push_back(e);
        wait_done("lone0");
        chk("pair_b_ptr_model", ptr_m, 1);
        run_pair("pair_b");

`ifdef MODEXP_ARB_TIMEOUT_EN
        engine_hang = 1'b1;
        base0 = 4; exp0 = 13; modulus0 = 497;
        base1 = 2; exp1 = 10; modulus1 = 1000;
        req0 = 1'b1;
        wait_start("timeout");
        req1 = 1'b1;
        n = 0;
        for (int i = 0; i < 100 && !(done0 || done1); i++) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, 17);
        chk("timeout_err", err, 1);
        chk("timeout_done", {done0, done1}, 2'b10);
        chk("timeout_result0", result0, 0);
        req0 = 1'b0;
        engine_hang = 1'b0;
        e.owner = 1; e.res = 24; e.err = 0;
        sb.push_back(e);
        wait_done("after_timeout");
`endif

        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

endmodule
